// File: rtl/eo_drain_pkg.sv
// rtl/eo_drain_pkg.sv - shared widths and types for the even_odd drain controller
package eo_pkg;

    localparam int EO_DW       = 8;
    localparam int EO_UP_DEPTH = 16;

    typedef logic [EO_DW-1:0]   eo_byte_t;
    typedef logic [2*EO_DW-1:0] eo_word_t;

endpackage

// File: rtl/eo_drain_if.sv
// rtl/eo_drain_if.sv - packed word valid/ready stream interface
interface eo_drain_if #(
    parameter int DW = 8
);

    logic [2*DW-1:0] word_data;
    logic            word_valid;
    logic            word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/eo_word_fifo.sv
// rtl/eo_word_fifo.sv - synchronous word FIFO with registered head data
module eo_word_fifo
    import eo_pkg::*;
#(
    parameter int W     = $bits(eo_word_t),
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [W-1:0]               head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          do_push, do_pop;

    // Pointer/count bookkeeping and next head word; a push into an empty
    // (or just-drained) FIFO bypasses memory straight into the head register.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        head_d   = head_q;
        if (do_pop) begin
            if (count_q == CW'(1)) begin
                if (do_push) head_d = push_data;
            end else begin
                head_d = mem_q[rd_ptr_q + AW'(1)];
            end
        end else if ((count_q == '0) && do_push) begin
            head_d = push_data;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    // Control state and registered head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/eo_drain.sv
// rtl/eo_drain.sv - even_odd read drain and byte packer (optional EO_DRAIN_STATS_EN counters)
module eo_drain
    import eo_pkg::*;
#(
    parameter int DW        = EO_DW,
    parameter int UP_DEPTH  = EO_UP_DEPTH,
    parameter int OUT_DEPTH = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          w_en_mon,
    output logic                          r_en,
    input  logic [DW-1:0]                 eo_d_out,
    eo_drain_if.master                    word_if,
    output logic [$clog2(UP_DEPTH+1)-1:0] credit,
    output logic                          half_pending,
`ifdef EO_DRAIN_STATS_EN
    output logic [15:0]                   word_cnt,
    output logic [15:0]                   stall_cnt,
`endif
    output logic                          ovf_err
);

    localparam int CW  = $clog2(UP_DEPTH+1);
    localparam int FCW = $clog2(OUT_DEPTH+1);

    logic [CW-1:0]     credit_q, credit_d;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic              half_q, half_d;
    logic [DW-1:0]     low_q, low_d;
    logic              ovf_q, ovf_d;

    logic [FCW-1:0]    fifo_count;
    logic              fifo_full, fifo_empty;
    logic              fifo_push, fifo_pop;
    logic [2*DW-1:0]   fifo_head;
    logic              capture;
    int                occ;

    // Read strobe from registered state only: every byte already owed to
    // the FIFO (queued, half-packed, or in flight) must still fit.
    always_comb begin
        occ = 2 * int'(fifo_count) + int'(half_q);
        for (int i = 0; i < RD_LAT; i++) occ += int'(rd_pipe_q[i]);
        r_en = (credit_q != '0) && (occ < 2 * OUT_DEPTH);
    end

    // Credit tracking, read-latency pipe and byte pairing.
    always_comb begin
        credit_d = credit_q;
        ovf_d    = ovf_q;
        if (w_en_mon && !r_en) begin
            if (credit_q == CW'(UP_DEPTH)) ovf_d = 1'b1;
            else                            credit_d = credit_q + CW'(1);
        end else if (!w_en_mon && r_en) begin
            credit_d = credit_q - CW'(1);
        end

        rd_pipe_d = RD_LAT'({rd_pipe_q, r_en});
        capture   = rd_pipe_q[RD_LAT-1];

        half_d    = half_q;
        low_d     = low_q;
        fifo_push = 1'b0;
        if (capture) begin
            if (!half_q) begin
                low_d  = eo_d_out;
                half_d = 1'b1;
            end else begin
                fifo_push = !fifo_full || fifo_pop;
                half_d    = 1'b0;
            end
        end
    end

    // Drain-side state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q  <= '0;
            rd_pipe_q <= '0;
            half_q    <= 1'b0;
            low_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            credit_q  <= credit_d;
            rd_pipe_q <= rd_pipe_d;
            half_q    <= half_d;
            low_q     <= low_d;
            ovf_q     <= ovf_d;
        end
    end

    assign fifo_pop = !fifo_empty && word_if.word_ready;

    eo_word_fifo #(
        .W     (2*DW),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({eo_d_out, low_q}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign word_if.word_valid = !fifo_empty;
    assign word_if.word_data  = fifo_head;
    assign credit             = credit_q;
    assign half_pending       = half_q;
    assign ovf_err            = ovf_q;

`ifdef EO_DRAIN_STATS_EN
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Popped-word count wraps; stall count saturates.
    always_comb begin
        word_cnt_d  = fifo_pop ? word_cnt_q + 16'd1 : word_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((credit_q != '0) && !r_en && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Statistics counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
